mac_unit: RTL and testbench
===========================

// Module: mac_unit
// PURPOSE
// - Registered multiply-accumulate cell for the perceptron datapath: out <= previous_out + x*w.
// - Cells are chained; each cell's out feeds the next cell's previous_out to form a dot product.
// - The perceptron top level thresholds the final out to produce the activation.
// PARAMETERS
// - XW_WIDTH   4  width of the x and w operands
// - ACC_WIDTH  8  width of previous_out and out; must be >= 2*XW_WIDTH
// - SIGNED     0  0: all operands unsigned; 1: x, w, previous_out and out are two's complement
// PORTS
// - clk           in   1          rising-edge clock, the only clock
// - rst_n         in   1          reset, asynchronous, active-high (1 = reset); codebase port name kept
// - en            in   1          accept the operands this cycle
// - x             in   XW_WIDTH   sample operand
// - w             in   XW_WIDTH   weight operand
// - previous_out  in   ACC_WIDTH  partial sum from the upstream cell (0 for the first cell)
// - out           out  ACC_WIDTH  registered accumulated result
// - out_valid     out  1          high for one cycle, the cycle after an accepted op
// - overflow      out  1          the last accepted op exceeded the ACC_WIDTH range
// BEHAVIOUR
// - Reset (rst_n=1, asynchronous): out=0, out_valid=0, overflow=0, applied immediately.
// - Reset has priority over en and is held for as long as rst_n=1.
// - An op in flight when reset asserts is discarded.
// - Latency is 1 cycle, with no handshake back-pressure.
// - At a rising edge with en=1:
//   - prod = x*w at full width (2*XW_WIDTH), extended according to SIGNED.
//   - sum = previous_out + prod, computed at ACC_WIDTH+1 bits.
//   - out <= sum truncated to ACC_WIDTH, so it wraps modulo 2^ACC_WIDTH.
//   - out_valid <= 1.
// - At a rising edge with en=0: out and overflow hold; out_valid <= 0.
// - Overflow with SIGNED=0: bit ACC_WIDTH of sum is 1.
// - Overflow with SIGNED=1: sum lies outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
// - overflow is registered together with out and updates only when en=1, so it is not sticky.
// - Back-to-back ops with en high every cycle give one result per cycle.
// - Operands are sampled only at the clock edge; no combinational path from inputs to outputs.
// - Width rule: with the defaults, prod is at most 225 unsigned, or 64 / -56 signed.
// - Elaboration error if ACC_WIDTH < 2*XW_WIDTH.
// CONFIGURATION
// - Macro MAC_SAT_EN defined: on overflow, out saturates instead of wrapping.
//   - SIGNED=0: saturates to 2^ACC_WIDTH-1.
//   - SIGNED=1: saturates to 2^(ACC_WIDTH-1)-1 if positive, -2^(ACC_WIDTH-1) if negative.
//   - overflow is still reported.
// - Macro MAC_SAT_EN undefined: modulo wrap as described in BEHAVIOUR.
//   - overflow is still reported.
// TESTING
// - Reset: rst_n=1 mid-cycle -> out=0, out_valid=0, overflow=0 immediately, before the next edge.
// - Basic, defaults: en=1, x=2, w=4, previous_out=0 -> next cycle out=8, out_valid=1, overflow=0.
// - Chain: cell0 (x=2, w=4, prev=0) feeds cell1 (x=3, w=9) -> cell1 out=35 two cycles after issue.
// - Wrap, no macro: x=15, w=15, previous_out=100 -> out=69, overflow=1.
//   - Same stimulus with MAC_SAT_EN -> out=255, overflow=1.
// - Signed, SIGNED=1: x=4'hF (-1), w=3, previous_out=0 -> out=8'hFD (-3), overflow=0.
//   - x=-8, w=-8, previous_out=100 -> overflow=1; out=8'hA4 wrapped, or 127 with MAC_SAT_EN.
// - Hold: en=0 for 3 cycles after out=8 -> out stays 8, out_valid=0, overflow unchanged.

Source files
------------

// File: rtl/mac_unit_if.sv
// rtl/mac_unit_if.sv - operand/result bundle for one multiply-accumulate cell
interface mac_unit_if #(
    parameter int XW_WIDTH  = 4,
    parameter int ACC_WIDTH = 8
);
    logic                 en;
    logic [XW_WIDTH-1:0]  x;
    logic [XW_WIDTH-1:0]  w;
    logic [ACC_WIDTH-1:0] previous_out;
    logic [ACC_WIDTH-1:0] out;
    logic                 out_valid;
    logic                 overflow;

    modport master (
        output en, x, w, previous_out,
        input  out, out_valid, overflow
    );

    modport slave (
        input  en, x, w, previous_out,
        output out, out_valid, overflow
    );
endinterface

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - registered multiply-accumulate cell, out <= previous_out + x*w
// Optional MAC_SAT_EN: saturate on overflow instead of wrapping.
module mac_unit #(
    parameter int XW_WIDTH  = 4,
    parameter int ACC_WIDTH = 8,
    parameter int SIGNED    = 0
) (
    input logic       clk,
    input logic       rst_n,
    mac_unit_if.slave bus
);
    localparam int PW = 2 * XW_WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    generate
        if (ACC_WIDTH < 2 * XW_WIDTH) begin : g_width_check
            $error("mac_unit: ACC_WIDTH must be >= 2*XW_WIDTH");
        end
    endgenerate

    logic                 is_signed;
    logic [PW-1:0]        x_ext;
    logic [PW-1:0]        w_ext;
    logic [PW-1:0]        prod;
    logic [SW-1:0]        prod_ext;
    logic [SW-1:0]        prev_ext;
    logic [SW-1:0]        sum;
    logic                 ovf_next;
    logic [ACC_WIDTH-1:0] out_next;

    assign is_signed = (SIGNED != 0);

    // Extending both operands to the product width first makes the low PW bits
    // of the product correct for either signedness.
    assign x_ext    = {{XW_WIDTH{is_signed & bus.x[XW_WIDTH-1]}}, bus.x};
    assign w_ext    = {{XW_WIDTH{is_signed & bus.w[XW_WIDTH-1]}}, bus.w};
    assign prod     = x_ext * w_ext;
    assign prod_ext = {{(SW-PW){is_signed & prod[PW-1]}}, prod};
    assign prev_ext = {is_signed & bus.previous_out[ACC_WIDTH-1], bus.previous_out};
    assign sum      = prev_ext + prod_ext;

    always_comb begin
        ovf_next = 1'b0;
        out_next = sum[ACC_WIDTH-1:0];
        if (is_signed) begin
            ovf_next = sum[SW-1] ^ sum[ACC_WIDTH-1];
        end else begin
            ovf_next = sum[SW-1];
        end
`ifdef MAC_SAT_EN
        if (ovf_next) begin
            if (!is_signed) begin
                out_next = '1;
            end else if (sum[SW-1]) begin
                out_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                out_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.out_valid <= bus.en;
            if (bus.en) begin
                bus.out      <= out_next;
                bus.overflow <= ovf_next;
            end
        end
    end
endmodule

// File: tb/tb_mac_unit.sv
// tb/tb_mac_unit.sv - directed bench for mac_unit (unsigned chain and signed cell)
module tb_mac_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mac_unit_if #(.XW_WIDTH(4), .ACC_WIDTH(8)) c0 ();
    mac_unit_if #(.XW_WIDTH(4), .ACC_WIDTH(8)) c1 ();
    mac_unit_if #(.XW_WIDTH(4), .ACC_WIDTH(8)) cs ();

    assign c1.previous_out = c0.out;

    mac_unit #(.XW_WIDTH(4), .ACC_WIDTH(8), .SIGNED(0)) u_c0 (.clk(clk), .rst_n(rst_n), .bus(c0.slave));
    mac_unit #(.XW_WIDTH(4), .ACC_WIDTH(8), .SIGNED(0)) u_c1 (.clk(clk), .rst_n(rst_n), .bus(c1.slave));
    mac_unit #(.XW_WIDTH(4), .ACC_WIDTH(8), .SIGNED(1)) u_cs (.clk(clk), .rst_n(rst_n), .bus(cs.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op0(input logic e, input logic [3:0] xv, input logic [3:0] wv, input logic [7:0] pv);
        c0.en = e; c0.x = xv; c0.w = wv; c0.previous_out = pv;
    endtask

    task automatic ops(input logic e, input logic [3:0] xv, input logic [3:0] wv, input logic [7:0] pv);
        cs.en = e; cs.x = xv; cs.w = wv; cs.previous_out = pv;
    endtask

    initial begin
        op0(1'b0, 4'd0, 4'd0, 8'd0);
        ops(1'b0, 4'd0, 4'd0, 8'd0);
        c1.en = 1'b0; c1.x = 4'd0; c1.w = 4'd0;
        step();
        step();
        rst_n = 1'b0;
        chk("reset_out", 32'(c0.out), 32'd0);
        chk("reset_valid", 32'(c0.out_valid), 32'd0);
        chk("reset_ovf", 32'(c0.overflow), 32'd0);

        // basic op then chained cell
        op0(1'b1, 4'd2, 4'd4, 8'd0);
        step();
        chk("basic_out", 32'(c0.out), 32'd8);
        chk("basic_valid", 32'(c0.out_valid), 32'd1);
        chk("basic_ovf", 32'(c0.overflow), 32'd0);
        op0(1'b0, 4'd0, 4'd0, 8'd0);
        c1.en = 1'b1; c1.x = 4'd3; c1.w = 4'd9;
        step();
        chk("chain_out", 32'(c1.out), 32'd35);
        chk("chain_valid", 32'(c1.out_valid), 32'd1);
        c1.en = 1'b0;
        chk("hold1_out", 32'(c0.out), 32'd8);
        chk("hold1_valid", 32'(c0.out_valid), 32'd0);
        for (int i = 2; i <= 3; i++) begin
            step();
            chk("hold_out", 32'(c0.out), 32'd8);
            chk("hold_valid", 32'(c0.out_valid), 32'd0);
            chk("hold_ovf", 32'(c0.overflow), 32'd0);
        end
        chk("chain_valid_drop", 32'(c1.out_valid), 32'd0);

        // unsigned overflow: 225 + 100 = 325
        op0(1'b1, 4'd15, 4'd15, 8'd100);
        step();
`ifdef MAC_SAT_EN
        chk("wrap_out", 32'(c0.out), 32'd255);
`else
        chk("wrap_out", 32'(c0.out), 32'd69);
`endif
        chk("wrap_ovf", 32'(c0.overflow), 32'd1);
        op0(1'b0, 4'd0, 4'd0, 8'd0);
        step();
        chk("ovf_hold", 32'(c0.overflow), 32'd1);
        // exactly 255: top of range, no overflow, and overflow clears
        op0(1'b1, 4'd15, 4'd15, 8'd30);
        step();
        chk("edge255_out", 32'(c0.out), 32'd255);
        chk("edge255_ovf", 32'(c0.overflow), 32'd0);
        op0(1'b0, 4'd0, 4'd0, 8'd0);

        // signed cell
        ops(1'b1, 4'hF, 4'd3, 8'd0);
        step();
        chk("sgn_neg_out", 32'(cs.out), 32'hFD);
        chk("sgn_neg_ovf", 32'(cs.overflow), 32'd0);
        ops(1'b1, 4'h8, 4'h8, 8'd100);
        step();
`ifdef MAC_SAT_EN
        chk("sgn_pos_ovf_out", 32'(cs.out), 32'h7F);
`else
        chk("sgn_pos_ovf_out", 32'(cs.out), 32'hA4);
`endif
        chk("sgn_pos_ovf", 32'(cs.overflow), 32'd1);
        // -8*7 + -100 = -156
        ops(1'b1, 4'h8, 4'd7, 8'h9C);
        step();
`ifdef MAC_SAT_EN
        chk("sgn_neg_ovf_out", 32'(cs.out), 32'h80);
`else
        chk("sgn_neg_ovf_out", 32'(cs.out), 32'h64);
`endif
        chk("sgn_neg_ovf", 32'(cs.overflow), 32'd1);
        // -8*7 + -72 = -128, bottom of range
        ops(1'b1, 4'h8, 4'd7, 8'hB8);
        step();
        chk("sgn_min_out", 32'(cs.out), 32'h80);
        chk("sgn_min_ovf", 32'(cs.overflow), 32'd0);
        ops(1'b0, 4'd0, 4'd0, 8'd0);

        // asynchronous reset mid-cycle, op in flight discarded
        op0(1'b1, 4'd2, 4'd4, 8'd0);
        step();
        chk("pre_rst_out", 32'(c0.out), 32'd8);
        #2;
        rst_n = 1'b1;
        #1;
        chk("async_rst_out", 32'(c0.out), 32'd0);
        chk("async_rst_valid", 32'(c0.out_valid), 32'd0);
        step();
        chk("rst_held_out", 32'(c0.out), 32'd0);
        chk("rst_held_valid", 32'(c0.out_valid), 32'd0);
        rst_n = 1'b0;
        op0(1'b0, 4'd0, 4'd0, 8'd0);
        step();
        chk("post_rst_out", 32'(c0.out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
